arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Per-client request buffer directly upstream of rr_arbiter.
- Each client pushes payload words into its own FIFO. The block drives `request[i]` while FIFO i is non-empty, pops on `grant[i]`, and presents the granted payload to the downstream consumer one cycle later.
- Guarantees the arbiter-side contract: a request is held stable until it is granted.

Parameters:
- CLIENTS, 32, number of clients; matches the arbiter CLIENTS.
- DEPTH, 4, entries per client FIFO; power of two, minimum 2.
- DATA_W, 8, payload width per entry.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  CLIENTS  per-client push strobe.
- push_data  input  CLIENTS*DATA_W  per-client payload; client i occupies bits [i*DATA_W +: DATA_W].
- full  output  CLIENTS  per-client FIFO full.
- request  output  CLIENTS  to arbiter `request`; bit i = FIFO i non-empty.
- grant  input  CLIENTS  from arbiter `grant`; one-hot or zero.
- stall  input  1  same signal as the arbiter `stall`; when 1, grants are ignored and nothing pops.
- out_valid  output  1  granted payload valid.
- out_client  output  $clog2(CLIENTS)  index of the granted client.
- out_data  output  DATA_W  granted payload.
- overflow  output  CLIENTS  sticky per client: push while full with no pop in the same cycle.
- grant_err  output  1  sticky: grant with no matching request, or a grant that is not one-hot.

Behaviour:
- Reset (asynchronous, takes effect immediately): all FIFOs empty, pointers and counts zero.
  - `request`, `full`, `out_valid`, `out_client`, `out_data`, `overflow`, `grant_err` all 0.
- Storage: per-client circular FIFO with read pointer, write pointer and a count of width $clog2(DEPTH)+1.
  - Pointers wrap from DEPTH-1 to 0.
- `request[i]` = (count_i != 0), decoded from registered state only. There is no combinational path from `grant` or `push` to `request`.
- `full[i]` = (count_i == DEPTH), decoded from registered state.
- Pop condition for client i: `grant[i] && request[i] && !stall`.
  - Head entry removed at that clock edge.
  - Next cycle: `out_valid`=1, `out_client`=i, `out_data`=head entry.
- `out_valid` is a single-cycle pulse per pop. Cycles with no pop give `out_valid`=0; `out_data` and `out_client` hold their last values.
- Push condition for client i: `push[i] && (!full[i] || pop_i)`.
  - Writes `push_data` slice i at the write pointer.
  - A push to an empty FIFO raises `request[i]` on the next cycle, so push-to-request latency is 1 cycle.
- Simultaneous push and pop on the same client: count unchanged, both pointers advance. This is legal at full and at count 1.
- Push while full without a pop: data dropped, count unchanged, `overflow[i]` set and held until reset.
- `grant[i]` with `request[i]`=0, or `grant` with more than one bit set: no pop on any client, `grant_err` set and held until reset.
- `stall`=1: no pops and no `out_valid`; pushes proceed normally.
- Requests from other clients are unaffected by any single client's push or pop.
- Reset mid-operation discards all queued entries, and any `out_valid` that would have been produced is suppressed.

Optional Feature:
- Macro ARB_REQ_QUEUE_SVA_EN.
- When defined, the module embeds concurrent assertions, each explicitly clocked `@(posedge clock)` and disabled during `reset`:
  - a `request[i]` that is not granted stays 1 on the next cycle;
  - `request[i] && grant[i] && !stall` implies count_i decrements by 1 unless a push occurs in the same cycle;
  - `out_valid` is 1 exactly one cycle after each pop;
  - `grant` is one-hot or zero (`$onehot0(grant)`);
  - count never exceeds DEPTH.
- It also embeds cover properties for FIFO full and for push+pop at full.
- When undefined, no assertion or cover code is compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset, then push client 4 with 0xA5 once, `grant`=0 → `request`=0x00000010 on cycle 1 and stays 0x00000010 for 10 cycles; `out_valid`=0.
- Push client 4 with 0x11, 0x22, 0x33, 0x44; then grant[4] for 4 cycles → `out_data` sequence 0x11, 0x22, 0x33, 0x44, each with `out_client`=4, one cycle after each grant; `request[4]`=0 after the 4th pop.
- Fill client 7 to DEPTH=4, then push 0x99 with no grant → `full[7]`=1, `overflow[7]`=1, count stays 4, and 0x99 is never output.
- Client 7 full, push 0x55 with grant[7] in the same cycle → head popped, 0x55 accepted, `full[7]` stays 1, `overflow[7]`=0.
- `stall`=1 with grant[2] and client 2 holding 1 entry → no `out_valid`, `request[2]` stays 1; after `stall`=0 with grant[2] → `out_valid`=1 the next cycle.
- `grant`=0x00000003 or grant[9] with client 9 empty → `grant_err`=1 (sticky), no FIFO counts change; assert reset mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/arb_req_queue.sv
// arb_req_queue: per-client request FIFOs that sit directly in front of
// rr_arbiter. A client's request is raised while its FIFO holds data, and
// is held stable until granted. The granted head entry is popped and
// presented downstream one cycle later.
// Optional assertion/cover set: define ARB_REQ_QUEUE_SVA_EN.
module arb_req_queue #(
  parameter int unsigned CLIENTS = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           push,
  input  logic [CLIENTS*DATA_W-1:0]    push_data,
  output logic [CLIENTS-1:0]           full,
  output logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS-1:0]           grant,
  input  logic                         stall,
  output logic                         out_valid,
  output logic [$clog2(CLIENTS)-1:0]   out_client,
  output logic [DATA_W-1:0]            out_data,
  output logic [CLIENTS-1:0]           overflow,
  output logic                         grant_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(CLIENTS);

  logic [CLIENTS-1:0] pop;
  logic [CLIENTS-1:0] push_ok;
  logic               grant_multi;
  logic               grant_unreq;
  logic               grant_bad;
  logic [DATA_W-1:0]  head [CLIENTS];
  logic [IDX_W-1:0]   pop_idx;
  logic [DATA_W-1:0]  pop_data;

  // Qualify grants: an illegal grant vector pops nothing on any client.
  always_comb begin
    grant_multi = (grant & (grant - CLIENTS'(1))) != '0;
    grant_unreq = (grant & ~request) != '0;
    grant_bad   = grant_multi || grant_unreq;
    pop         = (stall || grant_bad) ? '0 : (grant & request);
    push_ok     = push & (~full | pop);
  end

  for (genvar g = 0; g < CLIENTS; g++) begin : g_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Payload storage; contents are don't-care while the entry is unused.
    always_ff @(posedge clock) begin
      if (push_ok[g]) mem[wr_ptr] <= push_data[g*DATA_W +: DATA_W];
    end

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop[g])     rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_ok[g]) wr_ptr <= wr_ptr + PTR_W'(1);
        case ({push_ok[g], pop[g]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    assign request[g] = (count != '0);
    assign full[g]    = (count == CNT_W'(DEPTH));
    assign head[g]    = mem[rd_ptr];

`ifdef ARB_REQ_QUEUE_SVA_EN
    a_req_hold: assert property (@(posedge clock) disable iff (reset)
      request[g] && !grant[g] |=> request[g]);
    a_pop_dec: assert property (@(posedge clock) disable iff (reset)
      request[g] && grant[g] && !stall && $onehot0(grant) && !push_ok[g]
      |=> count == $past(count) - CNT_W'(1));
    a_cnt_max: assert property (@(posedge clock) disable iff (reset)
      count <= CNT_W'(DEPTH));
    c_full: cover property (@(posedge clock) disable iff (reset) full[g]);
    c_full_pushpop: cover property (@(posedge clock) disable iff (reset)
      full[g] && push_ok[g] && pop[g]);
`endif
  end

  // Select the popped client's index and head entry (pop is one-hot or zero).
  always_comb begin
    pop_idx  = '0;
    pop_data = '0;
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      if (pop[i]) begin
        pop_idx  = i[IDX_W-1:0];
        pop_data = head[i];
      end
    end
  end

  // Registered downstream output; data/client hold between pops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_client <= '0;
      out_data   <= '0;
    end else begin
      out_valid <= |pop;
      if (|pop) begin
        out_client <= pop_idx;
        out_data   <= pop_data;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= '0;
      grant_err <= 1'b0;
    end else begin
      overflow <= overflow | (push & full & ~pop);
      if (grant_bad && !stall) grant_err <= 1'b1;
    end
  end

`ifdef ARB_REQ_QUEUE_SVA_EN
  a_out_valid: assert property (@(posedge clock) disable iff (reset)
    (|pop) |=> out_valid);
  a_out_quiet: assert property (@(posedge clock) disable iff (reset)
    !(|pop) |=> !out_valid);
  a_grant_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(grant));
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed testbench for arb_req_queue (CLIENTS=32, DEPTH=4, DATA_W=8).
module tb_arb_req_queue;

  logic         clock;
  logic         reset;
  logic [31:0]  push;
  logic [255:0] push_data;
  logic [31:0]  full;
  logic [31:0]  request;
  logic [31:0]  grant;
  logic         stall;
  logic         out_valid;
  logic [4:0]   out_client;
  logic [7:0]   out_data;
  logic [31:0]  overflow;
  logic         grant_err;

  int n_cmp = 0;
  int n_err = 0;

  arb_req_queue #(.CLIENTS(32), .DEPTH(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .push(push), .push_data(push_data),
    .full(full), .request(request), .grant(grant), .stall(stall),
    .out_valid(out_valid), .out_client(out_client), .out_data(out_data),
    .overflow(overflow), .grant_err(grant_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push      = '0;
    push_data = '0;
    grant     = '0;
    stall     = 1'b0;
  endtask

  task automatic set_push(input int c, input logic [7:0] v);
    push              = '0;
    push_data         = '0;
    push[c]           = 1'b1;
    push_data[c*8 +: 8] = v;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (request !== 32'h0 || full !== 32'h0 || out_valid !== 1'b0 ||
        out_client !== 5'd0 || out_data !== 8'h00 || overflow !== 32'h0 ||
        grant_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: req=%h full=%h ov=%b oc=%0d od=%h ovf=%h ge=%b required all zero",
               request, full, out_valid, out_client, out_data, overflow, grant_err);
    end
  endtask

  task automatic test_request_latency();
    do_reset();
    set_push(4, 8'hA5);
    tick();
    idle();
    n_cmp++;
    if (request !== 32'h0000_0010) begin
      n_err++;
      $display("FAIL req_latency: got %h required 00000010", request);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (request !== 32'h0000_0010 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL req_hold cyc%0d: req=%h ov=%b required 00000010/0", k, request, out_valid);
      end
    end
  endtask

  task automatic test_pop_order();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_push(4, vals[k]);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      grant[4] = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_client !== 5'd4 || out_data !== vals[k]) begin
        n_err++;
        $display("FAIL pop_order%0d: ov=%b oc=%0d od=%h required 1/4/%h",
                 k, out_valid, out_client, out_data, vals[k]);
      end
    end
    n_cmp++;
    if (request[4] !== 1'b0) begin
      n_err++;
      $display("FAIL pop_drained: request[4]=%b required 0", request[4]);
    end
    grant = '0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h44 || out_client !== 5'd4) begin
      n_err++;
      $display("FAIL out_hold: ov=%b oc=%0d od=%h required 0/4/44", out_valid, out_client, out_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_push(7, 8'h71 + 8'(k));
      tick();
    end
    n_cmp++;
    if (full[7] !== 1'b1 || overflow[7] !== 1'b0) begin
      n_err++;
      $display("FAIL full_set: full7=%b ovf7=%b required 1/0", full[7], overflow[7]);
    end
    set_push(7, 8'h99);
    tick();
    idle();
    n_cmp++;
    if (full[7] !== 1'b1 || overflow[7] !== 1'b1 || overflow !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL overflow_set: full7=%b ovf=%h required 1/00000080", full[7], overflow);
    end
    for (int k = 0; k < 4; k++) begin
      grant[7] = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_client !== 5'd7 || out_data !== 8'h71 + 8'(k)) begin
        n_err++;
        $display("FAIL ovf_drain%0d: ov=%b oc=%0d od=%h required 1/7/%h",
                 k, out_valid, out_client, out_data, 8'h71 + 8'(k));
      end
    end
    grant = '0;
    n_cmp++;
    if (request[7] !== 1'b0 || overflow[7] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_empty: req7=%b ovf7=%b required 0/1", request[7], overflow[7]);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_tail [4];
    exp_tail[0] = 8'h62; exp_tail[1] = 8'h63; exp_tail[2] = 8'h64; exp_tail[3] = 8'h55;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_push(7, 8'h61 + 8'(k));
      tick();
    end
    set_push(7, 8'h55);
    grant[7] = 1'b1;
    tick();
    push = '0;
    grant = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h61 || full[7] !== 1'b1 || overflow[7] !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop_full: ov=%b od=%h full7=%b ovf7=%b required 1/61/1/0",
               out_valid, out_data, full[7], overflow[7]);
    end
    for (int k = 0; k < 4; k++) begin
      grant[7] = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_tail[k]) begin
        n_err++;
        $display("FAIL pushpop_drain%0d: ov=%b od=%h required 1/%h", k, out_valid, out_data, exp_tail[k]);
      end
    end
    grant = '0;
    n_cmp++;
    if (request[7] !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop_empty: req7=%b required 0", request[7]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_push(2, 8'h2C);
    tick();
    idle();
    stall    = 1'b1;
    grant[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || request[2] !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d: ov=%b req2=%b required 0/1", k, out_valid, request[2]);
      end
    end
    stall = 1'b0;
    tick();
    grant = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_client !== 5'd2 || out_data !== 8'h2C || request[2] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: ov=%b oc=%0d od=%h req2=%b required 1/2/2c/0",
               out_valid, out_client, out_data, request[2]);
    end
  endtask

  task automatic test_grant_err_and_reset();
    do_reset();
    set_push(0, 8'hA0);
    tick();
    set_push(1, 8'hB1);
    tick();
    set_push(5, 8'hC5);
    tick();
    idle();
    grant = 32'h0000_0003;
    tick();
    grant = '0;
    n_cmp++;
    if (grant_err !== 1'b1 || out_valid !== 1'b0 || request !== 32'h0000_0023) begin
      n_err++;
      $display("FAIL grant_multi: ge=%b ov=%b req=%h required 1/0/00000023", grant_err, out_valid, request);
    end
    do_reset();
    set_push(0, 8'hA0);
    tick();
    idle();
    grant[9] = 1'b1;
    tick();
    grant = '0;
    n_cmp++;
    if (grant_err !== 1'b1 || out_valid !== 1'b0 || request !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL grant_unreq: ge=%b ov=%b req=%h required 1/0/00000001", grant_err, out_valid, request);
    end
    grant[0] = 1'b1;
    tick();
    grant = '0;
    n_cmp++;
    if (grant_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA0 || out_client !== 5'd0) begin
      n_err++;
      $display("FAIL grant_err_sticky: ge=%b ov=%b od=%h oc=%0d required 1/1/a0/0",
               grant_err, out_valid, out_data, out_client);
    end
    // Mid-burst reset: assert between edges while a pop is in flight.
    set_push(3, 8'h33);
    tick();
    set_push(3, 8'h34);
    grant[3] = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (request !== 32'h0 || full !== 32'h0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_client !== 5'd0 || overflow !== 32'h0 || grant_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: req=%h ov=%b od=%h ge=%b required all zero",
               request, out_valid, out_data, grant_err);
    end
    tick();
    idle();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (request !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: req=%h ov=%b required 0/0", request, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_push(3, 8'hD3);
    tick();
    set_push(3, 8'hE3);
    tick();
    set_push(6, 8'hD6);
    grant[3] = 1'b1;
    tick();
    push = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hD3 || request !== 32'h0000_0048) begin
      n_err++;
      $display("FAIL b2b_a: ov=%b od=%h req=%h required 1/d3/00000048", out_valid, out_data, request);
    end
    grant = 32'h0000_0040;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_client !== 5'd6 || out_data !== 8'hD6 || request !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL b2b_b: ov=%b oc=%0d od=%h req=%h required 1/6/d6/00000008",
               out_valid, out_client, out_data, request);
    end
    grant = 32'h0000_0008;
    tick();
    grant = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_client !== 5'd3 || out_data !== 8'hE3 || request !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_c: ov=%b oc=%0d od=%h req=%h required 1/3/e3/0",
               out_valid, out_client, out_data, request);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_request_latency();
    test_pop_order();
    test_overflow();
    test_push_pop_full();
    test_stall();
    test_grant_err_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
